// File: rtl/flanken_pkg.sv
// Shared definitions for the flanken edge-counter bank: MODE encodings and the edge qualifier.
package flanken_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

  // Bit 0 of the mode enables rising edges, bit 1 enables falling edges.
  function automatic logic edge_hit(input mode_t m, input logic re, input logic fe);
    return (re & m[0]) | (fe & m[1]);
  endfunction

endpackage

// File: rtl/flanken_ch.sv
// One flanken channel: synchroniser, optional debounce (FLANKEN_DEBOUNCE_EN), history flop, counter, sticky OVF.
module flanken_ch
  import flanken_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SAT         = 0
`ifdef FLANKEN_DEBOUNCE_EN
  ,
  parameter int DEB_CYC     = 4
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sig,
  input  mode_t            mode,
  input  logic             clr,
  output logic             re,
  output logic             fe,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   filt_p1;
  logic                   hist_p2;
  logic                   hit;

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
    if (&c) return (SAT != 0) ? c : '0;
    return c + 1'b1;
  endfunction

  // Stage 0: synchroniser chain, shifting from bit 0 towards the MSB.
  always_ff @(posedge CLK) begin
    if (RST) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig};
  end

  // Stage 1: optional debounce between synchroniser and history.
`ifdef FLANKEN_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC + 1);
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_p1 <= 1'b0;
      deb_cnt <= '0;
    end else if (sync_p0[SYNC_STAGES-1] != filt_p1) begin
      if (deb_cnt == DW'(DEB_CYC - 1)) begin
        filt_p1 <= sync_p0[SYNC_STAGES-1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end
`else
  assign filt_p1 = sync_p0[SYNC_STAGES-1];
`endif

  assign re  = filt_p1 & ~hist_p2;
  assign fe  = ~filt_p1 & hist_p2;
  assign hit = edge_hit(mode, re, fe);

  // Stage 2: history flop and counter; CLR discards a coincident edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_p2 <= 1'b0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      hist_p2 <= filt_p1;
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (hit) begin
        cnt <= next_cnt(cnt);
        if (&cnt) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/flanken_bank.sv
// Bank of N_CH independent edge-detect/count channels; FLANKEN_DEBOUNCE_EN inserts a debounce filter per channel.
module flanken_bank
  import flanken_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SAT         = 0,
  parameter int DEB_CYC     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_CH-1:0]       SIGNAL,
  input  logic [2*N_CH-1:0]     MODE,
  input  logic [N_CH-1:0]       CLR,
  output logic [N_CH-1:0]       RE,
  output logic [N_CH-1:0]       FE,
  output logic [N_CH*CNT_W-1:0] COUNTER,
  output logic [N_CH-1:0]       OVF
);

  if (N_CH < 1 || N_CH > 32 || CNT_W < 2 || CNT_W > 32 || SYNC_STAGES < 2 ||
      SYNC_STAGES > 4 || DEB_CYC < 2 || DEB_CYC > 255) begin : g_bad_param
    $error("flanken_bank: parameter out of range");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    flanken_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .SAT         (SAT)
`ifdef FLANKEN_DEBOUNCE_EN
      ,
      .DEB_CYC     (DEB_CYC)
`endif
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .sig  (SIGNAL[i]),
      .mode (MODE[2*i +: 2]),
      .clr  (CLR[i]),
      .re   (RE[i]),
      .fe   (FE[i]),
      .cnt  (COUNTER[i*CNT_W +: CNT_W]),
      .ovf  (OVF[i])
    );
  end

endmodule

// File: tb/tb_flanken_bank.sv
// Scoreboard bench for flanken_bank: RE/FE event times queued at stimulus, popped when pulses appear.
module tb_flanken_bank;

  localparam int S = 2;
`ifdef FLANKEN_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int DEB = 4;
  localparam bit DEB_ON = 1'b0;
`endif
  localparam int LAT = S + (DEB_ON ? DEB : 0);

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  SIGNAL;
  logic [7:0]  MODE;
  logic [3:0]  CLR;
  logic [3:0]  RE, FE, OVF;
  logic [31:0] COUNTER;

  logic        sig_w, clr_w;
  logic [0:0]  re_w, fe_w, ovf_w, re_s, fe_s, ovf_s;
  logic [3:0]  cnt_w, cnt_s;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int re_q[4][$];
  int fe_q[4][$];
  int exp_cnt[4];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  flanken_bank #(.N_CH(4), .CNT_W(8), .SYNC_STAGES(S), .SAT(0), .DEB_CYC(DEB)) dut (
    .CLK(CLK), .RST(RST), .SIGNAL(SIGNAL), .MODE(MODE), .CLR(CLR),
    .RE(RE), .FE(FE), .COUNTER(COUNTER), .OVF(OVF));

  flanken_bank #(.N_CH(1), .CNT_W(4), .SYNC_STAGES(S), .SAT(0), .DEB_CYC(DEB)) u_w (
    .CLK(CLK), .RST(RST), .SIGNAL(sig_w), .MODE(2'b01), .CLR(clr_w),
    .RE(re_w), .FE(fe_w), .COUNTER(cnt_w), .OVF(ovf_w));

  flanken_bank #(.N_CH(1), .CNT_W(4), .SYNC_STAGES(S), .SAT(1), .DEB_CYC(DEB)) u_s (
    .CLK(CLK), .RST(RST), .SIGNAL(sig_w), .MODE(2'b01), .CLR(clr_w),
    .RE(re_s), .FE(fe_s), .COUNTER(cnt_s), .OVF(ovf_s));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int cnt_of(input int ch);
    return int'(COUNTER[ch*8 +: 8]);
  endfunction

  // Edge monitor: every observed pulse must match the next queued expectation.
  always @(negedge CLK) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (RE[ch]) begin
        if (re_q[ch].size() == 0) chk($sformatf("re%0d_unexpected", ch), cyc, -1);
        else chk($sformatf("re%0d_cycle", ch), cyc, re_q[ch].pop_front());
      end
      if (FE[ch]) begin
        if (fe_q[ch].size() == 0) chk($sformatf("fe%0d_unexpected", ch), cyc, -1);
        else chk($sformatf("fe%0d_cycle", ch), cyc, fe_q[ch].pop_front());
      end
    end
  end

  // Called at a negedge; pulses the masked channels high for len cycles.
  task automatic pulse(input logic [3:0] mask, input int len, input int gap);
    bit ok;
    ok = !DEB_ON || (len >= DEB);
    SIGNAL = SIGNAL | mask;
    for (int ch = 0; ch < 4; ch++)
      if (mask[ch] && ok) begin
        re_q[ch].push_back(cyc + LAT);
        if (MODE[2*ch]) exp_cnt[ch]++;
      end
    repeat (len) @(negedge CLK);
    SIGNAL = SIGNAL & ~mask;
    for (int ch = 0; ch < 4; ch++)
      if (mask[ch] && ok) begin
        fe_q[ch].push_back(cyc + LAT);
        if (MODE[2*ch+1]) exp_cnt[ch]++;
      end
    repeat (gap) @(negedge CLK);
  endtask

  task automatic wpulse(input int n);
    for (int i = 0; i < n; i++) begin
      sig_w = 1'b1;
      repeat (5) @(negedge CLK);
      sig_w = 1'b0;
      repeat (5) @(negedge CLK);
    end
    repeat (LAT + 2) @(negedge CLK);
  endtask

  task automatic chk_counts(input string tag);
    for (int ch = 0; ch < 4; ch++) chk($sformatf("%s_cnt%0d", tag, ch), cnt_of(ch), exp_cnt[ch]);
  endtask

  initial begin
    RST = 1'b1; SIGNAL = '0; MODE = '0; CLR = '0; sig_w = 1'b0; clr_w = 1'b0;
    for (int ch = 0; ch < 4; ch++) exp_cnt[ch] = 0;
    repeat (3) @(negedge CLK);
    chk("rst_counter", COUNTER, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_re", RE, 0);
    chk("rst_fe", FE, 0);
    RST = 1'b0;
    MODE = {2'b10, 2'b00, 2'b11, 2'b01};
    repeat (2) @(negedge CLK);

    // Single 10-cycle pulse on ch0 (rising only).
    pulse(4'b0001, 10, 10);
    chk_counts("single");

    // Three simultaneous pulses on ch1 (both), ch2 (off), ch3 (falling).
    for (int i = 0; i < 3; i++) pulse(4'b1110, 10, 10);
    chk_counts("multi");
    chk("multi_ovf", OVF, 0);

    // CLR in the same cycle as a qualifying RE on ch0.
    SIGNAL[0] = 1'b1;
    re_q[0].push_back(cyc + LAT);
    repeat (LAT) @(negedge CLK);
    chk("clr_coincide_re", RE[0], 1);
    CLR[0] = 1'b1;
    @(negedge CLK);
    CLR[0] = 1'b0;
    exp_cnt[0] = 0;
    chk("clr_coincide_cnt", cnt_of(0), 0);
    SIGNAL[0] = 1'b0;
    fe_q[0].push_back(cyc + LAT);
    repeat (LAT + 6) @(negedge CLK);
    chk("clr_after_cnt", cnt_of(0), 0);

    // 4-bit wrap and saturate instances.
    wpulse(15);
    chk("w15_cnt", cnt_w, 15);
    chk("w15_ovf", ovf_w, 0);
    chk("s15_ovf", ovf_s, 0);
    wpulse(2);
    chk("w17_cnt", cnt_w, 1);
    chk("w17_ovf", ovf_w, 1);
    chk("s17_cnt", cnt_s, 15);
    chk("s17_ovf", ovf_s, 1);
    clr_w = 1'b1;
    @(negedge CLK);
    clr_w = 1'b0;
    chk("wclr_cnt", cnt_w, 0);
    chk("wclr_ovf", ovf_w, 0);
    chk("sclr_cnt", cnt_s, 0);
    chk("sclr_ovf", ovf_s, 0);

    // Short glitch and a minimum-length pulse on ch0.
    pulse(4'b0001, 3, 12);
    pulse(4'b0001, 4, 12);
    chk_counts("short");

    // Bring ch0 to 5, then reset with SIGNAL[0] held high through release.
    exp_cnt[0] = 0;
    CLR[0] = 1'b1;
    @(negedge CLK);
    CLR[0] = 1'b0;
    for (int i = 0; i < 5; i++) pulse(4'b0001, 10, 10);
    chk("pre_rst_cnt0", cnt_of(0), 5);
    SIGNAL[0] = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_counter", COUNTER, 0);
    chk("mid_rst_ovf", OVF, 0);
    chk("mid_rst_re", RE, 0);
    chk("mid_rst_fe", FE, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int ch = 0; ch < 4; ch++) exp_cnt[ch] = 0;
    re_q[0].push_back(cyc + LAT);
    exp_cnt[0] = 1;
    repeat (LAT + 3) @(negedge CLK);
    chk_counts("post_rst");
    SIGNAL[0] = 1'b0;
    fe_q[0].push_back(cyc + LAT);
    repeat (LAT + 4) @(negedge CLK);

    for (int ch = 0; ch < 4; ch++) begin
      chk($sformatf("re%0d_pending", ch), re_q[ch].size(), 0);
      chk($sformatf("fe%0d_pending", ch), fe_q[ch].size(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
